instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequencer for the instruction memory: owns the program counter, drives `Read_Addr`, captures the 32-bit `instruction` word the memory returns, splits it into opcode/destination/source fields and hands each decoded instruction to the execute stage over a valid/ready handshake. It sits between the instruction memory and the register file/ALU control of the simple processor.

## Interface
- `ADDR_W`, 3: program counter and `Read_Addr` width.
- `PROG_LEN`, 8: number of instructions in the program (1..2^ADDR_W).
- `WRAP`, 0: 1 = restart at address 0 after the last instruction; 0 = stop in DONE.
- `clk` input 1: single clock. All logic is on the rising edge; the memory updates on the falling edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: pulse; begins fetching from address 0 when in IDLE or DONE.
- `jump` input 1: redirect request; loads the PC from `jump_addr`.
- `jump_addr` input ADDR_W: redirect target.
- `Read_Addr` output ADDR_W: instruction memory address.
- `instruction` input 32: instruction memory read data.
- `dec_valid` output 1: decoded fields are valid.
- `dec_ready` input 1: execute stage accepts the current instruction.
- `opcode` output 8: bits [31:24].
- `dest` output 8: bits [23:16].
- `src2` output 8: bits [15:8].
- `src1` output 8: bits [7:0]. This is the immediate for loadi.
- `is_loadi` output 1: `opcode` == 8'h08.
- `illegal` output 1: `opcode` is not in {00 mov, 01 add, 02 and, 03 or, 08 loadi, 09 sub}.
- `pc` output ADDR_W: address of the instruction currently presented.
- `done` output 1: program finished (only reachable with WRAP=0).

## Operation
- **States:** IDLE, FETCH, VALID, DONE.
- **IDLE:**
  - `start` -> pc=0, go to FETCH.
  - All other inputs are ignored, including `jump`.
- **FETCH:**
  - Lasts exactly one cycle. `Read_Addr`=pc is stable for the whole cycle.
  - The memory updates `instruction` on the falling edge inside this cycle.
  - On the next rising edge: capture `instruction` into the instruction register (IR), set dec_valid=1, go to VALID.
- **VALID:**
  - The fields are a combinational split of the IR.
  - The fields, dec_valid and pc are held stable until `dec_valid && dec_ready`.
  - On the handshake:
    - If pc == PROG_LEN-1 and WRAP=0: go to DONE, dec_valid=0.
    - If pc == PROG_LEN-1 and WRAP=1: pc=0, go to FETCH.
    - Otherwise: pc=pc+1, go to FETCH.
  - PC arithmetic is modulo 2^ADDR_W.
- **DONE:**
  - done=1, dec_valid=0, `Read_Addr` holds the last pc.
  - `start` -> pc=0, done=0, go to FETCH.
- **jump** (FETCH or VALID only):
  - pc=jump_addr, dec_valid=0, go to FETCH. Any pending instruction is dropped, even if `dec_ready` is high in the same cycle.
  - A `jump_addr` >= PROG_LEN is still fetched; only an address equal to PROG_LEN-1 triggers the end-of-program check.
- **Priority:** reset > jump > handshake > start.
- `Read_Addr` always equals pc.

## Timing
- **Reset values:** state IDLE, pc=0, Read_Addr=0, IR=0 (so all fields are 0), dec_valid=0, done=0. Consequently is_loadi=0 and illegal=0.
- Reset asserted mid-fetch or mid-VALID aborts on that edge. The next cycle shows all reset values.
- **Fetch latency:** 1 cycle from `Read_Addr` change to dec_valid=1.
- **Throughput:** with `dec_ready` held high, one instruction every 2 cycles.
- **Backpressure:** while dec_valid=1 and dec_ready=0, every output is frozen.
- dec_valid never drops without a handshake, except on jump or reset.
- `start` while in FETCH or VALID is ignored.

## Structure
- **Package `ifu_pkg`:**
  - opcode localparams: OP_MOV=8'h00, OP_ADD=8'h01, OP_AND=8'h02, OP_OR=8'h03, OP_LOADI=8'h08, OP_SUB=8'h09.
  - field bit positions.
  - state encoding.
- **Sub-module `instr_field_decode`:** the combinational split of the IR into opcode/dest/src2/src1 plus the is_loadi/illegal flags.
- **Top level:** holds the FSM, pc and IR.

## Test plan
- **Reset and start, PROG_LEN=8, memory program 0x080400FF, 0x080600AA, 0x080300BB, 0x01050603, 0x02010405, 0x03020106, 0x00070002, 0x09040703, dec_ready=1:**
  - Response: eight instructions, one every 2 cycles, then done=1.
  - Instruction 0: opcode=08, dest=04, src1=FF, is_loadi=1.
  - Instruction 3: opcode=01, dest=05, src2=06, src1=03.
- **Backpressure:** hold dec_ready=0 for 5 cycles at pc=3 -> fields stay 0x01/05/06/03 and Read_Addr stays 3; the release gives exactly one handshake, then Read_Addr=4.
- **Jump:** assert jump with jump_addr=6 while VALID at pc=1 and dec_ready=1 -> instruction 1 is not accepted; the next presented instruction is 0x00070002 (mov, dest 7, src1 2) with pc=6.
- **Wrap:** WRAP=1, PROG_LEN=4 -> pc sequence 0,1,2,3,0,1; done stays 0.
- **Illegal opcode:** memory word 0x05000000 -> illegal=1, dec_valid=1; it is still handed off normally.
- **Reset in VALID at pc=5:** the next cycle shows dec_valid=0, Read_Addr=0, state IDLE; a following `start` refetches 0x080400FF.

Source files
------------

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared constants for the instruction fetch unit. Holds the
//               opcode map, the bit positions of each field inside the 32-bit
//               instruction word, the fetch FSM state encoding and a helper
//               that classifies an opcode as legal.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    // Opcode map of the simple processor.
    localparam logic [7:0] OP_MOV   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_AND   = 8'h02;
    localparam logic [7:0] OP_OR    = 8'h03;
    localparam logic [7:0] OP_LOADI = 8'h08;
    localparam logic [7:0] OP_SUB   = 8'h09;

    // Field positions inside the instruction word.
    localparam int C_OPCODE_MSB = 31;
    localparam int C_OPCODE_LSB = 24;
    localparam int C_DEST_MSB   = 23;
    localparam int C_DEST_LSB   = 16;
    localparam int C_SRC2_MSB   = 15;
    localparam int C_SRC2_LSB   = 8;
    localparam int C_SRC1_MSB   = 7;
    localparam int C_SRC1_LSB   = 0;

    // Fetch FSM state encoding.
    localparam int          C_STATE_W = 2;
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_FETCH   = 2'd1;
    localparam logic [1:0]  S_VALID   = 2'd2;
    localparam logic [1:0]  S_DONE    = 2'd3;

    // True for every opcode the execute stage understands.
    function automatic logic op_is_legal(input logic [7:0] op);
        logic legal;
        case (op)
            OP_MOV, OP_ADD, OP_AND, OP_OR, OP_LOADI, OP_SUB: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_decode
// Description : Purely combinational split of the instruction register into
//               its four byte fields plus the loadi / illegal flags.
//   i_ir       : 32-bit instruction register
//   o_opcode   : bits [31:24]
//   o_dest     : bits [23:16]
//   o_src2     : bits [15:8]
//   o_src1     : bits [7:0] (immediate for loadi)
//   o_is_loadi : opcode is loadi
//   o_illegal  : opcode outside the supported set
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_decode
    import ifu_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [7:0]  o_opcode,
    output logic [7:0]  o_dest,
    output logic [7:0]  o_src2,
    output logic [7:0]  o_src1,
    output logic        o_is_loadi,
    output logic        o_illegal
);

    assign o_opcode   = i_ir[C_OPCODE_MSB:C_OPCODE_LSB];
    assign o_dest     = i_ir[C_DEST_MSB:C_DEST_LSB];
    assign o_src2     = i_ir[C_SRC2_MSB:C_SRC2_LSB];
    assign o_src1     = i_ir[C_SRC1_MSB:C_SRC1_LSB];
    assign o_is_loadi = (o_opcode == OP_LOADI);
    assign o_illegal  = !op_is_legal(o_opcode);

endmodule : instr_field_decode
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Program-counter sequencer for the instruction memory. Drives
//               Read_Addr, captures the returned word one cycle later into
//               the instruction register and presents the decoded fields to
//               the execute stage with a valid/ready handshake.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin fetching at address 0 (IDLE / DONE only)
//   jump, jump_addr       : redirect the PC (FETCH / VALID only)
//   Read_Addr             : instruction memory address (always equals pc)
//   instruction           : instruction memory read data
//   dec_valid, dec_ready  : handshake towards the execute stage
//   opcode/dest/src2/src1 : decoded fields of the presented instruction
//   is_loadi, illegal     : opcode classification flags
//   pc                    : address of the presented instruction
//   done                  : program finished (WRAP = 0 only)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int PROG_LEN = 8,
    parameter int WRAP     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] Read_Addr,
    input  logic [31:0]       instruction,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [7:0]        opcode,
    output logic [7:0]        dest,
    output logic [7:0]        src2,
    output logic [7:0]        src1,
    output logic              is_loadi,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc,
    output logic              done
);

    // Address of the final program instruction; PROG_LEN never exceeds
    // 2^ADDR_W so this always fits in the PC width.
    localparam logic [ADDR_W-1:0] C_LAST_PC = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0] C_PC_ONE  = ADDR_W'(1);

    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic [31:0]          r_ir;
    logic                 w_ir_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ir_load) begin
                r_ir <= instruction;
            end
        end
    end

    // Next-state logic. Inside FETCH/VALID a jump overrides everything,
    // including a handshake that would otherwise complete on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (jump) begin
                    // Word in flight belongs to the old PC; refetch instead.
                    w_pc_nxt = jump_addr;
                end else begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (jump) begin
                    w_pc_nxt    = jump_addr;
                    w_state_nxt = S_FETCH;
                end else if (dec_ready) begin
                    if (r_pc == C_LAST_PC) begin
                        if (WRAP != 0) begin
                            w_pc_nxt    = '0;
                            w_state_nxt = S_FETCH;
                        end else begin
                            // PC is left on the last address while DONE.
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_pc_nxt    = r_pc + C_PC_ONE;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign Read_Addr = r_pc;
    assign pc        = r_pc;
    assign dec_valid = (r_state == S_VALID);
    assign done      = (r_state == S_DONE);

    instr_field_decode u_decode (
        .i_ir       (r_ir),
        .o_opcode   (opcode),
        .o_dest     (dest),
        .o_src2     (src2),
        .o_src1     (src1),
        .o_is_loadi (is_loadi),
        .o_illegal  (illegal)
    );

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. One instance runs
//               the 8-instruction stop-at-end program, a second instance runs
//               a 4-instruction wrapping program. Directed steps are followed
//               by a randomized phase checked against a transaction-level
//               model of the expected program-counter stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, jump, dec_ready;
    logic [2:0]  jump_addr;
    logic [2:0]  Read_Addr, pc;
    logic [31:0] instruction;
    logic        dec_valid, is_loadi, illegal, done;
    logic [7:0]  opcode, dest, src2, src1;

    logic        start_w;
    logic [2:0]  Read_Addr_w, pc_w;
    logic [31:0] instruction_w;
    logic        dec_valid_w, is_loadi_w, illegal_w, done_w;
    logic [7:0]  opcode_w, dest_w, src2_w, src1_w;

    logic [31:0] mem   [0:7];
    logic [31:0] mem_w [0:7];
    logic [31:0] obs_word, obs_word_w;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Instruction memories update on the falling edge.
    always @(negedge clk) instruction   <= mem[Read_Addr];
    always @(negedge clk) instruction_w <= mem_w[Read_Addr_w];

    assign obs_word   = {opcode, dest, src2, src1};
    assign obs_word_w = {opcode_w, dest_w, src2_w, src1_w};

    instr_fetch_unit #(.ADDR_W(3), .PROG_LEN(8), .WRAP(0)) dut (
        .clk(clk), .reset(reset), .start(start), .jump(jump),
        .jump_addr(jump_addr), .Read_Addr(Read_Addr),
        .instruction(instruction), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .opcode(opcode), .dest(dest), .src2(src2),
        .src1(src1), .is_loadi(is_loadi), .illegal(illegal), .pc(pc),
        .done(done)
    );

    instr_fetch_unit #(.ADDR_W(3), .PROG_LEN(4), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .jump(1'b0),
        .jump_addr(3'd0), .Read_Addr(Read_Addr_w),
        .instruction(instruction_w), .dec_valid(dec_valid_w),
        .dec_ready(1'b1), .opcode(opcode_w), .dest(dest_w), .src2(src2_w),
        .src1(src1_w), .is_loadi(is_loadi_w), .illegal(illegal_w),
        .pc(pc_w), .done(done_w)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_pc(input logic [2:0] target, input int budget);
        int n = 0;
        while (!(dec_valid === 1'b1 && pc === target) && n < budget) begin
            step();
            n++;
        end
        check("wait_pc_reached", {31'd0, dec_valid === 1'b1 && pc === target}, 32'd1);
    endtask

    // Reference classification straight from the opcode table.
    function automatic logic exp_illegal(input logic [31:0] w);
        logic [7:0] op;
        op = w[31:24];
        return !(op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09});
    endfunction

    function automatic logic exp_loadi(input logic [31:0] w);
        logic [7:0] op;
        op = w[31:24];
        return op == 8'h08;
    endfunction

    task automatic load_program();
        mem[0] = 32'h080400FF; mem[1] = 32'h080600AA;
        mem[2] = 32'h080300BB; mem[3] = 32'h01050603;
        mem[4] = 32'h02010405; mem[5] = 32'h03020106;
        mem[6] = 32'h00070002; mem[7] = 32'h09040703;
    endtask

    logic [7:0] legal_ops [0:5];
    logic [2:0] exp_pc;
    logic       m_done;
    int         hs;
    int         budget;

    initial begin
        legal_ops[0] = 8'h00; legal_ops[1] = 8'h01; legal_ops[2] = 8'h02;
        legal_ops[3] = 8'h03; legal_ops[4] = 8'h08; legal_ops[5] = 8'h09;
        load_program();
        mem_w[0] = 32'h01111111; mem_w[1] = 32'h02222222;
        mem_w[2] = 32'h03333333; mem_w[3] = 32'h08444444;
        for (int i = 4; i < 8; i++) mem_w[i] = 32'hDEADBEEF;

        reset = 1'b1; start = 1'b0; jump = 1'b0; jump_addr = 3'd0;
        dec_ready = 1'b0; start_w = 1'b0;
        step(); step();
        reset = 1'b0;

        // Reset values.
        check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_read_addr", {29'd0, Read_Addr}, 32'd0);
        check("rst_pc",        {29'd0, pc},        32'd0);
        check("rst_fields",    obs_word,           32'd0);
        check("rst_flags",     {30'd0, is_loadi, illegal}, 32'd0);

        // Jump is ignored in IDLE.
        jump = 1'b1; jump_addr = 3'd5;
        step();
        jump = 1'b0;
        check("idle_jump_valid", {31'd0, dec_valid}, 32'd0);
        check("idle_jump_addr",  {29'd0, Read_Addr}, 32'd0);

        // Full program with dec_ready high: one instruction every 2 cycles.
        dec_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            check("seq_fetch_valid", {31'd0, dec_valid}, 32'd0);
            check("seq_fetch_addr",  {29'd0, Read_Addr}, k);
            step();
            check("seq_valid",  {31'd0, dec_valid}, 32'd1);
            check("seq_pc",     {29'd0, pc},        k);
            check("seq_word",   obs_word,           mem[k]);
            check("seq_loadi",  {31'd0, is_loadi},  {31'd0, exp_loadi(mem[k])});
            check("seq_illegal",{31'd0, illegal},   {31'd0, exp_illegal(mem[k])});
            if (k == 0) begin
                check("i0_opcode", {24'd0, opcode}, 32'h08);
                check("i0_dest",   {24'd0, dest},   32'h04);
                check("i0_src1",   {24'd0, src1},   32'hFF);
                check("i0_loadi",  {31'd0, is_loadi}, 32'd1);
            end
            if (k == 3) begin
                check("i3_opcode", {24'd0, opcode}, 32'h01);
                check("i3_dest",   {24'd0, dest},   32'h05);
                check("i3_src2",   {24'd0, src2},   32'h06);
                check("i3_src1",   {24'd0, src1},   32'h03);
            end
            step();
        end
        check("end_done",      {31'd0, done},      32'd1);
        check("end_valid",     {31'd0, dec_valid}, 32'd0);
        check("end_read_addr", {29'd0, Read_Addr}, 32'd7);
        step();
        check("end_done_hold", {31'd0, done},      32'd1);

        // Backpressure at pc=3.
        dec_ready = 1'b0;
        pulse_start();
        check("restart_done", {31'd0, done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_pc(k[2:0], 4);
            dec_ready = 1'b1;
            step();
            dec_ready = 1'b0;
        end
        wait_pc(3'd3, 4);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);   // start while VALID must be ignored
            step();
            check("bp_word",  obs_word,           32'h01050603);
            check("bp_addr",  {29'd0, Read_Addr}, 32'd3);
            check("bp_valid", {31'd0, dec_valid}, 32'd1);
        end
        start = 1'b0;
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("bp_release_valid", {31'd0, dec_valid}, 32'd0);
        check("bp_release_addr",  {29'd0, Read_Addr}, 32'd4);
        step();
        check("bp_next_valid", {31'd0, dec_valid}, 32'd1);
        check("bp_next_pc",    {29'd0, pc},        32'd4);

        // Jump while VALID at pc=1 with dec_ready high.
        reset = 1'b1; step(); reset = 1'b0;
        pulse_start();
        dec_ready = 1'b1;
        wait_pc(3'd1, 6);
        jump = 1'b1; jump_addr = 3'd6;
        step();
        jump = 1'b0;
        check("jmp_valid", {31'd0, dec_valid}, 32'd0);
        check("jmp_addr",  {29'd0, Read_Addr}, 32'd6);
        step();
        check("jmp_tgt_valid", {31'd0, dec_valid}, 32'd1);
        check("jmp_tgt_pc",    {29'd0, pc},        32'd6);
        check("jmp_tgt_word",  obs_word,           32'h00070002);
        step(); step(); step();
        check("jmp_end_done", {31'd0, done}, 32'd1);

        // Illegal opcode is flagged but handed off normally.
        mem[2] = 32'h05000000;
        pulse_start();
        wait_pc(3'd2, 8);
        check("ill_flag",   {31'd0, illegal},   32'd1);
        check("ill_valid",  {31'd0, dec_valid}, 32'd1);
        check("ill_opcode", {24'd0, opcode},    32'h05);
        step();
        check("ill_handoff_addr",  {29'd0, Read_Addr}, 32'd3);
        check("ill_handoff_valid", {31'd0, dec_valid}, 32'd0);
        load_program();

        // Reset while VALID at pc=5, then restart.
        wait_pc(3'd5, 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rv_valid",  {31'd0, dec_valid}, 32'd0);
        check("rv_addr",   {29'd0, Read_Addr}, 32'd0);
        check("rv_done",   {31'd0, done},      32'd0);
        check("rv_fields", obs_word,           32'd0);
        step();
        check("rv_idle_valid", {31'd0, dec_valid}, 32'd0);
        pulse_start();
        step();
        check("rv_refetch_pc",   {29'd0, pc}, 32'd0);
        check("rv_refetch_word", obs_word,    32'h080400FF);

        // Wrapping instance: pc 0,1,2,3,0,1 and never done.
        dec_ready = 1'b0;
        start_w = 1'b1; step(); start_w = 1'b0;
        for (int i = 0; i < 6; i++) begin
            budget = 0;
            while (dec_valid_w !== 1'b1 && budget < 4) begin
                step();
                budget++;
            end
            check("wrap_valid", {31'd0, dec_valid_w}, 32'd1);
            check("wrap_pc",    {29'd0, pc_w},        i % 4);
            check("wrap_word",  obs_word_w,           mem_w[i % 4]);
            check("wrap_done",  {31'd0, done_w},      32'd0);
            step();
        end

        // Randomized phase against a model of the expected PC stream.
        for (int i = 0; i < 8; i++) begin
            int r;
            r = $urandom_range(0, 6);
            mem[i] = {(r < 6) ? legal_ops[r] : 8'($urandom), 24'($urandom)};
        end
        reset = 1'b1; step(); reset = 1'b0;
        pulse_start();
        exp_pc = 3'd0; m_done = 1'b0; hs = 0;
        for (int c = 0; c < 400; c++) begin
            check("rnd_done", {31'd0, done},      {31'd0, m_done});
            check("rnd_addr", {29'd0, Read_Addr}, {29'd0, exp_pc});
            if (m_done) check("rnd_done_valid", {31'd0, dec_valid}, 32'd0);
            if (dec_valid === 1'b1) begin
                check("rnd_pc",      {29'd0, pc},      {29'd0, exp_pc});
                check("rnd_word",    obs_word,         mem[exp_pc]);
                check("rnd_illegal", {31'd0, illegal}, {31'd0, exp_illegal(mem[exp_pc])});
                check("rnd_loadi",   {31'd0, is_loadi},{31'd0, exp_loadi(mem[exp_pc])});
            end
            jump      = ($urandom_range(0, 9) == 0);
            jump_addr = 3'($urandom_range(0, 7));
            dec_ready = 1'($urandom_range(0, 1));
            start     = m_done ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
            if (!m_done) begin
                if (jump) begin
                    exp_pc = jump_addr;
                end else if (dec_valid === 1'b1 && dec_ready) begin
                    hs++;
                    if (exp_pc == 3'd7) m_done = 1'b1;
                    else exp_pc = exp_pc + 3'd1;
                end
            end else if (start) begin
                m_done = 1'b0;
                exp_pc = 3'd0;
            end
            step();
        end
        jump = 1'b0; start = 1'b0; dec_ready = 1'b0;
        check("rnd_handshakes", {31'd0, hs > 20}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
